// File: rtl/wait_event_pkg.sv
// rtl/wait_event_pkg.sv - shared types for the wait-on-signal-edge engine
package wait_event_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT,
      DONE
   } state_t;

   typedef enum logic {
      EDGE_FALL = 1'b0,
      EDGE_RISE = 1'b1
   } edge_t;

endpackage

// File: rtl/wait_event_sync_edge_detect.sv
// rtl/wait_event_sync_edge_detect.sv - per-bit 2-flop synchronizer with history flop and edge vectors
module sync_edge_detect #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sig,
   output logic [W-1:0] sync,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= sig;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/wait_event.sv
// rtl/wait_event.sv - waits for a rising/falling edge on one selected signal, with optional timeout
module wait_event
   import wait_event_pkg::*;
#(
   parameter int  SIG_NB    = 8,
   parameter int  TIMEOUT_W = 32,
   // one extra code point so an out-of-range index can reach the error path
   localparam int IDX_W     = $clog2(SIG_NB + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_sel_wait,
   input  logic                 i_edge_rise,
   input  logic [IDX_W-1:0]     i_sig_idx,
   input  logic [TIMEOUT_W-1:0] i_timeout,
   input  logic [SIG_NB-1:0]    i_wait_signals,
   output logic                 o_wait_done,
   output logic                 o_timeout,
   output logic                 o_err,
   output logic                 o_busy
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIG_NB - 1);

   state_t               state_q, state_d;
   edge_t                edge_q;
   logic [IDX_W-1:0]     idx_q;
   logic [TIMEOUT_W-1:0] timeout_q;
   logic [TIMEOUT_W-1:0] cnt_q;
   logic                 to_q, err_q;
   logic                 set_to, set_err;

   logic [SIG_NB-1:0]    sync_vec, rise_vec, fall_vec;
   logic                 sync_sel, rise_sel, fall_sel;
   logic                 edge_hit, to_hit;

   sync_edge_detect #(.W(SIG_NB)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (i_wait_signals),
      .sync  (sync_vec),
      .rise  (rise_vec),
      .fall  (fall_vec)
   );

   always_comb begin
      sync_sel = 1'b0;
      rise_sel = 1'b0;
      fall_sel = 1'b0;
      for (int i = 0; i < SIG_NB; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sync_sel = sync_vec[i];
            rise_sel = rise_vec[i];
            fall_sel = fall_vec[i];
         end
      end
   end

   // a transition counts only when the new level matches the requested polarity
   assign edge_hit = (rise_sel || fall_sel) && (sync_sel == (edge_q == EDGE_RISE));
   assign to_hit   = (timeout_q != '0) && (cnt_q == timeout_q - TIMEOUT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      set_to  = 1'b0;
      set_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_sel_wait) state_d = ARM;
         end
         ARM: begin
            if (!i_sel_wait) begin
               state_d = IDLE;
            end else if (idx_q > IDX_LAST) begin
               state_d = DONE;
               set_err = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!i_sel_wait) begin
               state_d = IDLE;
            end else if (edge_hit) begin
               state_d = DONE;
            end else if (to_hit) begin
               state_d = DONE;
               set_to  = 1'b1;
            end
         end
         DONE: begin
            if (!i_sel_wait) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_q    <= EDGE_FALL;
         idx_q     <= '0;
         timeout_q <= '0;
         cnt_q     <= '0;
         to_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == IDLE && i_sel_wait) begin
            edge_q    <= edge_t'(i_edge_rise);
            idx_q     <= i_sig_idx;
            timeout_q <= i_timeout;
         end
         // saturating so an unbounded wait never wraps into a false timeout
         if (state_q == ARM) begin
            cnt_q <= '0;
         end else if (state_q == WAIT && cnt_q != '1) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
         end
         if (state_d == IDLE) begin
            to_q  <= 1'b0;
            err_q <= 1'b0;
         end else begin
            if (set_to)  to_q  <= 1'b1;
            if (set_err) err_q <= 1'b1;
         end
      end
   end

   assign o_wait_done = (state_q == DONE);
   assign o_timeout   = to_q;
   assign o_err       = err_q;
   assign o_busy      = (state_q != IDLE);

endmodule
